// File: rtl/draw_pkg.sv
// Shared definitions for the VGA drawing chain: timing/colour widths,
// glyph geometry and the text reveal FSM state encoding.
package draw_pkg;

  localparam int HC_W         = 11;
  localparam int RGB_W        = 12;
  localparam int GLYPH_W      = 8;
  localparam int GLYPH_W_LOG2 = 3;

  // Reveal FSM states, kept as plain constants so older blocks can reuse them
  typedef logic [1:0] reveal_state_t;
  localparam reveal_state_t ST_IDLE   = 2'd0;
  localparam reveal_state_t ST_REVEAL = 2'd1;
  localparam reveal_state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/delay.sv
// Generic register pipeline used to keep timing strobes aligned with the
// pixel path. CLK_DEL stages of WIDTH bits, cleared by async active-low reset.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
)(
  input  logic             pclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [CLK_DEL];

  // Shift the input through CLK_DEL register stages
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/text_reveal_ctrl.sv
// Typewriter reveal controller: counts frame ticks and exposes one more
// character cell every REVEAL_FRAMES frames until all CELLS are shown.
module text_reveal_ctrl
  import draw_pkg::*;
#(
  parameter int CELLS         = 96,
  parameter int REVEAL_FRAMES = 4,
  parameter int RV_W          = 7
)(
  input  logic            pclk,
  input  logic            rst,
  input  logic            start,
  input  logic            frame_tick,
  output logic [RV_W-1:0] revealed,
  output reveal_state_t   state,
  output logic            done
);

  localparam int FC_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt;

  // FSM and counters; a start pulse always restarts the reveal, even on a tick
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      frame_cnt <= '0;
      revealed  <= '0;
    end else if (start) begin
      state     <= ST_REVEAL;
      frame_cnt <= '0;
      revealed  <= '0;
    end else if (state == ST_REVEAL && frame_tick) begin
      if (frame_cnt == FC_W'(REVEAL_FRAMES - 1)) begin
        frame_cnt <= '0;
        revealed  <= revealed + RV_W'(1);
        if (revealed == RV_W'(CELLS - 1)) state <= ST_DONE;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  // Completion flag, registered one cycle behind the DONE state
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) done <= 1'b0;
    else      done <= (state == ST_DONE);
  end

endmodule

// File: rtl/draw_text_box.sv
// Text-box overlay: draws a ROWS x COLS grid of 8-pixel glyphs with integer
// scaling, fed by an external text ROM + font ROM pair, with a typewriter
// reveal. Two-cycle pipeline from timing inputs to all outputs.
// Optional macro DRAW_TEXT_BOX_BORDER_EN adds a 1-pixel colour_fg frame
// around the box while it is visible.
module draw_text_box
  import draw_pkg::*;
#(
  parameter int COLS          = 16,
  parameter int ROWS          = 6,
  parameter int FONT_H        = 16,
  parameter int SCALE_LOG2    = 0,
  parameter int REVEAL_FRAMES = 4
)(
  input  logic                              pclk,
  input  logic                              rst,
  input  logic [10:0]                       hcount_in,
  input  logic [10:0]                       vcount_in,
  input  logic                              hsync_in,
  input  logic                              hblnk_in,
  input  logic                              vsync_in,
  input  logic                              vblnk_in,
  input  logic [11:0]                       rgb_in,
  input  logic [11:0]                       xpos,
  input  logic [11:0]                       ypos,
  input  logic [11:0]                       color_fg,
  input  logic [11:0]                       color_bg,
  input  logic                              start,
  input  logic [7:0]                        char_pixels,
  output logic [10:0]                       hcount_out,
  output logic [10:0]                       vcount_out,
  output logic                              hsync_out,
  output logic                              hblnk_out,
  output logic                              vsync_out,
  output logic                              vblnk_out,
  output logic [11:0]                       rgb_out,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0] char_xy,
  output logic [$clog2(FONT_H)-1:0]         char_line,
  output logic                              done
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int LW    = $clog2(FONT_H);
  localparam int CELLS = ROWS * COLS;
  localparam int RV_W  = $clog2(CELLS + 1);
  localparam logic [12:0] BOX_W = 13'((COLS * GLYPH_W) << SCALE_LOG2);
  localparam logic [12:0] BOX_H = 13'((ROWS * FONT_H) << SCALE_LOG2);

  logic [11:0]     xl, yl;
  logic            frame_tick;
  logic [12:0]     h13, v13, x13, y13;
  logic [12:0]     dx, dy, col_full, row_full, cell_idx;
  logic            inside_now, cell_vis_now;
  logic [RV_W-1:0] revealed;
  reveal_state_t   state;
  logic            s1_inside, s1_vis, s1_blank;
  logic [2:0]      s1_bit;
  logic [11:0]     s1_rgb;
  logic [25:0]     timing_d;
`ifdef DRAW_TEXT_BOX_BORDER_EN
  logic            ring_now, s1_ring;
`endif

  assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 11'd0);

  text_reveal_ctrl #(
    .CELLS        (CELLS),
    .REVEAL_FRAMES(REVEAL_FRAMES),
    .RV_W         (RV_W)
  ) u_ctrl (
    .pclk      (pclk),
    .rst       (rst),
    .start     (start),
    .frame_tick(frame_tick),
    .revealed  (revealed),
    .state     (state),
    .done      (done)
  );

  // Box position is sampled once per frame so mid-frame moves do not tear
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      xl <= '0;
      yl <= '0;
    end else if (frame_tick) begin
      xl <= xpos;
      yl <= ypos;
    end
  end

  // Box hit test and cell/glyph coordinates in 13-bit space so xl+W never wraps
  always_comb begin
    h13          = {2'b00, hcount_in};
    v13          = {2'b00, vcount_in};
    x13          = {1'b0, xl};
    y13          = {1'b0, yl};
    inside_now   = (h13 >= x13) && (h13 < x13 + BOX_W) &&
                   (v13 >= y13) && (v13 < y13 + BOX_H);
    dx           = (h13 - x13) >> SCALE_LOG2;
    dy           = (v13 - y13) >> SCALE_LOG2;
    col_full     = dx >> GLYPH_W_LOG2;
    row_full     = dy >> LW;
    cell_idx     = row_full * 13'(COLS) + col_full;
    cell_vis_now = (state == ST_DONE) || (cell_idx < 13'(revealed));
`ifdef DRAW_TEXT_BOX_BORDER_EN
    ring_now     = (h13 + 13'd1 >= x13) && (h13 <= x13 + BOX_W) &&
                   (v13 + 13'd1 >= y13) && (v13 <= y13 + BOX_H) && !inside_now;
`endif
  end

  // Stage 1: address the ROMs and carry pixel context alongside the lookup
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      char_xy   <= '0;
      char_line <= '0;
      s1_inside <= 1'b0;
      s1_bit    <= '0;
      s1_vis    <= 1'b0;
      s1_rgb    <= '0;
      s1_blank  <= 1'b0;
`ifdef DRAW_TEXT_BOX_BORDER_EN
      s1_ring   <= 1'b0;
`endif
    end else begin
      char_xy   <= {row_full[RW-1:0], col_full[CW-1:0]};
      char_line <= dy[LW-1:0];
      s1_inside <= inside_now && (state != ST_IDLE);
      s1_bit    <= dx[2:0];
      s1_vis    <= cell_vis_now;
      s1_rgb    <= rgb_in;
      s1_blank  <= hblnk_in || vblnk_in;
`ifdef DRAW_TEXT_BOX_BORDER_EN
      s1_ring   <= ring_now && (state != ST_IDLE);
`endif
    end
  end

  // Stage 2: compose the output pixel; bit 7 of the font row is the leftmost
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      rgb_out <= '0;
    end else if (s1_blank) begin
      rgb_out <= '0;
    end else if (s1_inside) begin
      rgb_out <= (s1_vis && char_pixels[3'd7 - s1_bit]) ? color_fg : color_bg;
`ifdef DRAW_TEXT_BOX_BORDER_EN
    end else if (s1_ring) begin
      rgb_out <= color_fg;
`endif
    end else begin
      rgb_out <= s1_rgb;
    end
  end

  delay #(
    .WIDTH  (26),
    .CLK_DEL(2)
  ) u_timing_delay (
    .pclk(pclk),
    .rst (rst),
    .din ({hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in}),
    .dout(timing_d)
  );

  assign {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} = timing_d;

endmodule

// File: tb/tb_draw_text_box.sv
// Self-checking bench for draw_text_box: two instances (unscaled with
// REVEAL_FRAMES=2, and 2x scaled with REVEAL_FRAMES=1) share one stimulus
// stream; a queue scoreboard holds model pixels until the DUT outputs them.
module tb_draw_text_box;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos, color_fg, color_bg;
  logic        start;
  logic [7:0]  char_pixels, char_pixels_s;

  logic [10:0] hcount_out, vcount_out, hcount_out_s, vcount_out_s;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic        hsync_out_s, hblnk_out_s, vsync_out_s, vblnk_out_s;
  logic [11:0] rgb_out, rgb_out_s;
  logic [6:0]  char_xy, char_xy_s;
  logic [3:0]  char_line, char_line_s;
  logic        done, done_s;

  always #5 pclk = ~pclk;

  draw_text_box #(.COLS(16), .ROWS(6), .FONT_H(16), .SCALE_LOG2(0), .REVEAL_FRAMES(2)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .color_fg(color_fg), .color_bg(color_bg),
    .start(start), .char_pixels(char_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .char_xy(char_xy), .char_line(char_line), .done(done)
  );

  draw_text_box #(.COLS(16), .ROWS(6), .FONT_H(16), .SCALE_LOG2(1), .REVEAL_FRAMES(1)) dut_s (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .color_fg(color_fg), .color_bg(color_bg),
    .start(start), .char_pixels(char_pixels_s),
    .hcount_out(hcount_out_s), .vcount_out(vcount_out_s),
    .hsync_out(hsync_out_s), .hblnk_out(hblnk_out_s), .vsync_out(vsync_out_s), .vblnk_out(vblnk_out_s),
    .rgb_out(rgb_out_s), .char_xy(char_xy_s), .char_line(char_line_s), .done(done_s)
  );

  // Font ROM stand-in: a glyph row derived from {row, col, line}, bit 7 always set
  function automatic logic [7:0] glyph(int row, int col, int line);
    logic [7:0] g;
    g = 8'((col * 37 + row * 11 + line * 3) & 'h7E);
    return g | 8'h80;
  endfunction

  assign char_pixels   = glyph(int'(char_xy[6:4]), int'(char_xy[3:0]), int'(char_line));
  assign char_pixels_s = glyph(int'(char_xy_s[6:4]), int'(char_xy_s[3:0]), int'(char_line_s));

  typedef struct {
    string       tag;
    logic [11:0] exp0;
    logic [11:0] exp1;
    logic [25:0] tim;
    int          target;
  } sb_t;

  sb_t sbq[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  // Reference model state
  int xl_m = 0, yl_m = 0, ticks_m = 0;
  bit drawn_m = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int rev0();
    return (ticks_m / 2 > 96) ? 96 : ticks_m / 2;
  endfunction

  function automatic int rev1();
    return (ticks_m > 96) ? 96 : ticks_m;
  endfunction

  function automatic logic [11:0] model_rgb(int x, int y, logic [11:0] rin, logic blank, int s, int rev);
    int w, h, dx, dy, col, row, line, b;
    logic [7:0] g;
    w = 128 << s;
    h = 96 << s;
    if (blank) return 12'h000;
    if (!drawn_m) return rin;
    if (x >= xl_m && x < xl_m + w && y >= yl_m && y < yl_m + h) begin
      dx   = (x - xl_m) >> s;
      dy   = (y - yl_m) >> s;
      col  = dx / 8;
      b    = dx % 8;
      row  = dy / 16;
      line = dy % 16;
      g    = glyph(row, col, line);
      if ((row * 16 + col) < rev && g[7 - b]) return color_fg;
      return color_bg;
    end
`ifdef DRAW_TEXT_BOX_BORDER_EN
    if (x + 1 >= xl_m && x <= xl_m + w && y + 1 >= yl_m && y <= yl_m + h) return color_fg;
`endif
    return rin;
  endfunction

  // Drive one pixel for one cycle and queue what both instances must output
  task automatic applyStimulus(input string tag, input int x, input int y,
                               input logic hb, input logic vb, input logic st);
    sb_t e;
    hcount_in = 11'(x);
    vcount_in = 11'(y);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = 1'($urandom_range(0, 1));
    vsync_in  = 1'($urandom_range(0, 1));
    rgb_in    = 12'($urandom_range(0, 4095));
    start     = st;
    e.tag    = tag;
    e.exp0   = model_rgb(x, y, rgb_in, hb | vb, 0, rev0());
    e.exp1   = model_rgb(x, y, rgb_in, hb | vb, 1, rev1());
    e.tim    = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};
    e.target = cyc + 2;
    sbq.push_back(e);
    if (st) begin
      drawn_m = 1'b1;
      ticks_m = 0;
    end else if (x == 0 && y == 0 && drawn_m) begin
      ticks_m++;
    end
    if (x == 0 && y == 0) begin
      xl_m = int'(xpos);
      yl_m = int'(ypos);
    end
    @(negedge pclk);
  endtask

  // Park inputs on a neutral pixel and wait (bounded) for the scoreboard to empty
  task automatic drainQueue();
    int n;
    n = 0;
    start     = 1'b0;
    hcount_in = 11'd5;
    vcount_in = 11'd5;
    while (sbq.size() > 0 && n < 10) begin
      @(negedge pclk);
      n++;
    end
    if (sbq.size() > 0) begin
      checkOutput("drain", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  // Scoreboard: compare each queued expectation when its output cycle arrives
  always @(negedge pclk) begin
    sb_t e;
    while (sbq.size() > 0 && sbq[0].target <= cyc) begin
      e = sbq.pop_front();
      checkOutput({e.tag, "/rgb"}, 32'(rgb_out), 32'(e.exp0));
      checkOutput({e.tag, "/rgb_s"}, 32'(rgb_out_s), 32'(e.exp1));
      checkOutput({e.tag, "/tim"},
                  32'({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}),
                  32'(e.tim));
    end
  end

  initial begin
    rst       = 1'b0;
    hcount_in = 11'd5;
    vcount_in = 11'd7;
    hsync_in  = 1'b1;
    hblnk_in  = 1'b0;
    vsync_in  = 1'b1;
    vblnk_in  = 1'b0;
    rgb_in    = 12'hABC;
    xpos      = 12'd100;
    ypos      = 12'd50;
    color_fg  = 12'hFA5;
    color_bg  = 12'h1C3;
    start     = 1'b0;
    repeat (3) @(negedge pclk);

    checkOutput("rst_rgb", 32'(rgb_out), 32'd0);
    checkOutput("rst_xy", 32'(char_xy), 32'd0);
    checkOutput("rst_tim", 32'({hcount_out, vcount_out, hsync_out, vsync_out}), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);

    rst = 1'b1;
    @(negedge pclk);

    // Hidden while idle
    applyStimulus("tick", 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("idle", 100, 50, 1'b0, 1'b0, 1'b0);

    // Start on a frame-start tick: the tick must not count
    applyStimulus("start", 0, 0, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus("tick", 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("rv1_c0", 100, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus("rv1_c1", 108, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus("rv1_c2", 116, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus("tick", 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("rv2_c1", 108, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus("rv2_c2", 116, 50, 1'b0, 1'b0, 1'b0);

    while (ticks_m < 191) applyStimulus("tick", 0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("done_pre", 32'(done), 32'd0);
    applyStimulus("tick192", 0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("done_lag", 32'(done), 32'd0);
    applyStimulus("post", 5, 5, 1'b0, 1'b0, 1'b0);
    checkOutput("done", 32'(done), 32'd1);
    checkOutput("done_s", 32'(done_s), 32'd1);

    // Fully revealed box: glyph bit order and edges
    applyStimulus("p100", 100, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus("p101", 101, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus("p99", 99, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus("p228", 228, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus("p227", 227, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus("p102", 102, 50, 1'b0, 1'b0, 1'b0);
    applyStimulus("bot_in", 100, 145, 1'b0, 1'b0, 1'b0);
    applyStimulus("bot_out", 100, 146, 1'b0, 1'b0, 1'b0);

    // ROM addressing, including the scaled column step at x=116
    for (int x = 100; x <= 116; x++) begin
      applyStimulus("xy", x, 50, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("xy_s@%0d", x), 32'(char_xy_s), 32'({3'd0, 4'(((x - 100) >> 1) / 8)}));
      checkOutput($sformatf("xy@%0d", x), 32'(char_xy), 32'({3'd0, 4'((x - 100) / 8)}));
    end
    applyStimulus("xy_r2", 120, 83, 1'b0, 1'b0, 1'b0);
    checkOutput("xy_r2", 32'(char_xy), 32'({3'd2, 4'd2}));
    checkOutput("line_r2", 32'(char_line), 32'd1);

    // Random pixels around the box, occasionally blanked
    for (int i = 0; i < 40; i++) begin
      applyStimulus("rnd", int'($urandom_range(90, 370)), int'($urandom_range(40, 260)),
                    1'($urandom_range(0, 7) == 0), 1'b0, 1'b0);
    end

    // Blanking forces black inside the box
    applyStimulus("hblnk", 120, 60, 1'b1, 1'b0, 1'b0);
    applyStimulus("vblnk", 130, 70, 1'b0, 1'b1, 1'b0);

    // Mid-frame ypos change only takes effect after the next frame start
    ypos = 12'd60;
    applyStimulus("ymid", 100, 55, 1'b0, 1'b0, 1'b0);
    applyStimulus("tick", 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("ynew_out", 100, 55, 1'b0, 1'b0, 1'b0);
    applyStimulus("ynew_in", 100, 60, 1'b0, 1'b0, 1'b0);
    applyStimulus("edge9960", 99, 60, 1'b0, 1'b0, 1'b0);
    applyStimulus("edge1059", 105, 59, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a reveal
    applyStimulus("restart", 5, 5, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus("tick", 0, 0, 1'b0, 1'b0, 1'b0);
    drainQueue();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_rgb", 32'(rgb_out), 32'd0);
    checkOutput("arst_rgb_s", 32'(rgb_out_s), 32'd0);
    checkOutput("arst_xy", 32'(char_xy), 32'd0);
    checkOutput("arst_tim", 32'({hcount_out, vcount_out, hsync_out, vsync_out}), 32'd0);
    xl_m    = 0;
    yl_m    = 0;
    drawn_m = 1'b0;
    ticks_m = 0;
    @(negedge pclk);
    rst = 1'b1;
    applyStimulus("tick", 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus("hidden", 100, 60, 1'b0, 1'b0, 1'b0);
    applyStimulus("hidden2", 150, 90, 1'b0, 1'b0, 1'b0);
    checkOutput("arst_done", 32'(done), 32'd0);
    applyStimulus("restart2", 5, 5, 1'b0, 1'b0, 1'b1);
    applyStimulus("shown", 100, 60, 1'b0, 1'b0, 1'b0);
    drainQueue();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
